// File: rtl/fir_sequencer_if.sv
// Handshake and datapath-control bundle between the FIR sequencer and its
// environment (stream producer/consumer plus the MAC datapath).
interface fir_sequencer_if #(
  parameter int AWIDTH = 5
);
  logic              req_in;
  logic              ack_in;
  logic              req_out;
  logic              ack_out;
  logic              sample_we;
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] coef_sel;
  logic [AWIDTH-1:0] tap_sel;
  logic              acc_clr;
  logic              acc_en;
  logic              out_latch;
  logic              busy;

  // Sequencer side
  modport master (
    output req_in,
    input  ack_in,
    output req_out,
    input  ack_out,
    output sample_we,
    output wr_ptr,
    output coef_sel,
    output tap_sel,
    output acc_clr,
    output acc_en,
    output out_latch,
    output busy
  );

  // Producer/consumer/datapath side
  modport slave (
    input  req_in,
    output ack_in,
    input  req_out,
    output ack_out,
    input  sample_we,
    input  wr_ptr,
    input  coef_sel,
    input  tap_sel,
    input  acc_clr,
    input  acc_en,
    input  out_latch,
    input  busy
  );
endinterface

// File: rtl/fir_sequencer.sv
// Control FSM for a time-multiplexed single-multiplier FIR: runs the four-phase
// input/output handshakes and issues one MAC step per tap with explicit addresses.
module fir_sequencer #(
  parameter int NR_STAGES = 32,
  parameter int AWIDTH    = 5,
  parameter int MAC_LAT   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  fir_sequencer_if.master          ctl
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ_IN   = 3'd1,
    WAIT_IN  = 3'd2,
    MAC      = 3'd3,
    DRAIN    = 3'd4,
    REQ_OUT  = 3'd5,
    WAIT_OUT = 3'd6
  } state_e;

  localparam logic [AWIDTH-1:0] LAST_STEP = AWIDTH'(NR_STAGES - 1);
  localparam logic [2:0]        LAST_LAT  = 3'(MAC_LAT - 1);

  generate
    if ((1 << AWIDTH) != NR_STAGES || NR_STAGES < 2 || MAC_LAT < 1 || MAC_LAT > 4) begin : g_bad_params
      $error("fir_sequencer: NR_STAGES must equal 2**AWIDTH (>= 2) and MAC_LAT must be 1..4");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] ctr_q, ctr_d;
  logic [2:0]        lat_q, lat_d;
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic              req_in_q, req_in_d;
  logic              req_out_q, req_out_d;

  logic              sample_we;
  logic              acc_clr;
  logic              acc_en;
  logic              out_latch;
  logic [AWIDTH-1:0] coef_sel;
  logic [AWIDTH-1:0] tap_sel;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    ctr_d     = ctr_q;
    lat_d     = lat_q;
    wr_ptr_d  = wr_ptr_q;
    sample_we = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    out_latch = 1'b0;
    coef_sel  = '0;
    tap_sel   = '0;

    unique case (state_q)
      IDLE: begin
        state_d = REQ_IN;
      end

      REQ_IN: begin
        if (ctl.ack_in) begin
          sample_we = 1'b1;
          state_d   = WAIT_IN;
        end
      end

      WAIT_IN: begin
        if (!ctl.ack_in) begin
          acc_clr = 1'b1;
          ctr_d   = '0;
          state_d = MAC;
        end
      end

      MAC: begin
        // Tap k reads the sample written k samples ago; truncation gives the wrap.
        acc_en   = 1'b1;
        coef_sel = ctr_q;
        tap_sel  = wr_ptr_q - ctr_q;
        ctr_d    = ctr_q + 1'b1;
        if (ctr_q == LAST_STEP) begin
          lat_d   = '0;
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (lat_q == LAST_LAT) begin
          out_latch = 1'b1;
          wr_ptr_d  = wr_ptr_q + 1'b1;
          state_d   = REQ_OUT;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      REQ_OUT: begin
        if (ctl.ack_out) begin
          state_d = WAIT_OUT;
        end
      end

      WAIT_OUT: begin
        if (!ctl.ack_out) begin
          state_d = REQ_IN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Requests are registered copies of the next state so they never glitch.
    req_in_d  = (state_d == REQ_IN);
    req_out_d = (state_d == REQ_OUT);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      // NOTE: only control state is reset; the sample RAM in the datapath keeps its contents.
      state_q   <= IDLE;
      ctr_q     <= '0;
      lat_q     <= '0;
      wr_ptr_q  <= '0;
      req_in_q  <= 1'b0;
      req_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      lat_q     <= lat_d;
      wr_ptr_q  <= wr_ptr_d;
      req_in_q  <= req_in_d;
      req_out_q <= req_out_d;
    end
  end

  assign ctl.req_in    = req_in_q;
  assign ctl.req_out   = req_out_q;
  assign ctl.sample_we = sample_we;
  assign ctl.wr_ptr    = wr_ptr_q;
  assign ctl.coef_sel  = coef_sel;
  assign ctl.tap_sel   = tap_sel;
  assign ctl.acc_clr   = acc_clr;
  assign ctl.acc_en    = acc_en;
  assign ctl.out_latch = out_latch;
  assign ctl.busy      = !(state_q == IDLE || state_q == REQ_IN);

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer (4 taps, MAC_LAT=1) with a behavioural MAC
// datapath and a scoreboard of golden FIR outputs.
module tb_fir_sequencer;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int L  = 1;
  localparam logic [7:0] H [N] = '{8'd1, 8'd2, 8'd3, 8'd4};

  logic clk = 1'b0;
  logic rst;
  logic [7:0] data_in;

  always #5 clk = ~clk;

  fir_sequencer_if #(.AWIDTH(AW)) ctl ();

  fir_sequencer #(
    .NR_STAGES(N),
    .AWIDTH   (AW),
    .MAC_LAT  (L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ctl(ctl)
  );

  // Behavioural datapath: sample RAM, coefficient lookup, accumulator, output register
  logic [7:0]  ram [N] = '{default: 8'd0};
  logic [31:0] acc     = '0;
  logic [31:0] out_reg = '0;
  int          we_cnt  = 0;
  int          log_n   = 0;
  logic [AW-1:0] log_coef [256];
  logic [AW-1:0] log_tap  [256];

  always_ff @(posedge clk) begin
    if (ctl.sample_we) begin
      ram[ctl.wr_ptr] <= data_in;
      we_cnt          <= we_cnt + 1;
    end
    if (ctl.acc_clr) begin
      acc <= '0;
    end else if (ctl.acc_en) begin
      acc                   <= acc + 32'(ram[ctl.tap_sel]) * 32'(H[ctl.coef_sel]);
      log_coef[log_n[7:0]]  <= ctl.coef_sel;
      log_tap[log_n[7:0]]   <= ctl.tap_sel;
      log_n                 <= log_n + 1;
    end
    if (ctl.out_latch) begin
      out_reg <= acc;
    end
  end

  // Golden model: ring of accepted samples indexed as the spec defines the delay line
  logic [7:0] ref_ring [N] = '{default: 8'd0};
  int ref_wp = 0;
  int exp_q [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] outs();
    return 32'({ctl.req_in, ctl.req_out, ctl.sample_we, ctl.acc_clr, ctl.acc_en,
                ctl.out_latch, ctl.busy, ctl.wr_ptr, ctl.coef_sel, ctl.tap_sel});
  endfunction

  function automatic int model_y();
    int s = 0;
    for (int k = 0; k < N; k++) s += int'(H[k]) * int'(ref_ring[(ref_wp - k) & (N - 1)]);
    return s;
  endfunction

  task automatic send(input logic [7:0] x, input int hold);
    int n = 0;
    while (!ctl.req_in && n < 200) begin
      step();
      n++;
    end
    check("req_in_seen", 32'(ctl.req_in), 1);
    data_in    = x;
    ctl.ack_in = 1'b1;
    ref_ring[ref_wp] = x;
    exp_q.push_back(model_y());
    ref_wp = (ref_wp + 1) % N;
    #1;
    check("sample_we_on_ack", 32'(ctl.sample_we), 1);
    repeat (hold) step();
    ctl.ack_in = 1'b0;
  endtask

  task automatic recv(input string tag, input int stall, input bit stray_in);
    int n = 0;
    int bad = 0;
    int we0;
    int exp;
    while (!ctl.req_out && n < 200) begin
      step();
      n++;
    end
    check({tag, "_req_out"}, 32'(ctl.req_out), 1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    check({tag, "_y"}, out_reg, exp);
    we0 = we_cnt;
    for (int i = 0; i < stall; i++) begin
      ctl.ack_in = stray_in && (i == 5);
      step();
      if (!ctl.req_out || ctl.req_in || ctl.sample_we) bad++;
    end
    ctl.ack_in = 1'b0;
    check({tag, "_stall_hold"}, 32'(bad), 0);
    check({tag, "_no_stray_we"}, 32'(we_cnt - we0), 0);
    ctl.ack_out = 1'b1;
    step();
    check({tag, "_req_out_drop"}, 32'(ctl.req_out), 0);
    check({tag, "_busy_wait_out"}, 32'(ctl.busy), 1);
    ctl.ack_out = 1'b0;
    step();
    check({tag, "_req_in_again"}, 32'(ctl.req_in), 1);
  endtask

  task automatic check_log(input string tag, input int base, input int wp);
    check({tag, "_steps"}, 32'(log_n - base), N);
    for (int k = 0; k < N; k++) begin
      check({tag, "_coef"}, 32'(log_coef[base + k]), 32'(k));
      check({tag, "_tap"},  32'(log_tap[base + k]),  32'((wp - k) & (N - 1)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int we0;
    int lat;
    int n;

    rst         = 1'b1;
    ctl.ack_in  = 1'b0;
    ctl.ack_out = 1'b0;
    data_in     = '0;

    // Reset state, then REQ_IN with acks low
    repeat (3) step();
    check("reset_outs", outs(), 0);
    rst = 1'b0;
    step();
    check("idle_to_req_in", outs(), 32'h1000);
    step();
    check("req_in_stays", outs(), 32'h1000);

    // Sample 1: impulse, cycle by cycle
    base = log_n;
    we0  = we_cnt;
    send(8'd1, 1);
    #1;
    lat = 1;
    check("s1_acc_clr", 32'(ctl.acc_clr), 1);
    check("s1_req_in_low", 32'(ctl.req_in), 0);
    check("s1_busy", 32'(ctl.busy), 1);
    for (int k = 0; k < N; k++) begin
      step();
      lat++;
      check("s1_acc_en", 32'(ctl.acc_en), 1);
      check("s1_coef_sel", 32'(ctl.coef_sel), 32'(k));
      check("s1_tap_sel", 32'(ctl.tap_sel), 32'((0 - k) & (N - 1)));
    end
    step();
    lat++;
    check("s1_out_latch", 32'(ctl.out_latch), 1);
    check("s1_drain_no_acc", 32'(ctl.acc_en), 0);
    check("s1_no_early_req_out", 32'(ctl.req_out), 0);
    step();
    lat++;
    check("s1_req_out", 32'(ctl.req_out), 1);
    check("s1_latency", 32'(lat), 1 + N + L + 1);
    check("s1_wr_ptr", 32'(ctl.wr_ptr), 1);
    check("s1_one_we", 32'(we_cnt - we0), 1);
    recv("s1", 0, 1'b0);
    check_log("s1", base, 0);

    // Samples 2..4 complete the impulse response; wr_ptr wraps to 0
    for (int i = 1; i < N; i++) begin
      base = log_n;
      send(8'd0, 1);
      recv("imp", 0, 1'b0);
      check_log("imp", base, i);
    end
    check("wr_ptr_wrap", 32'(ctl.wr_ptr), 0);

    // ack_in held 5 cycles; stray ack_out during MAC
    base = log_n;
    we0  = we_cnt;
    send(8'd5, 5);
    #1;
    check("hold_one_we", 32'(we_cnt - we0), 1);
    check("hold_acc_clr", 32'(ctl.acc_clr), 1);
    step();
    check("hold_mac_start", 32'(ctl.acc_en), 1);
    ctl.ack_out = 1'b1;
    step();
    ctl.ack_out = 1'b0;
    check("stray_ack_out_acc_en", 32'(ctl.acc_en), 1);
    check("stray_ack_out_req_out", 32'(ctl.req_out), 0);
    recv("hold", 0, 1'b0);
    check_log("hold", base, 0);

    // Consumer stalls 20 cycles; stray ack_in while waiting
    send(8'd3, 1);
    recv("stall", 20, 1'b1);

    // Reset at MAC step 2 aborts the sample; RAM keeps the written value
    send(8'd7, 1);
    n = 0;
    while (!(ctl.acc_en && ctl.coef_sel == 2'd2) && n < 50) begin
      step();
      n++;
    end
    check("rst_at_step2_reached", 32'(ctl.coef_sel), 2);
    rst = 1'b1;
    step();
    check("rst_mid_mac_outs", outs(), 0);
    rst = 1'b0;
    void'(exp_q.pop_back());
    ref_wp = 0;
    send(8'd2, 1);
    recv("post_rst", 0, 1'b0);
    check("post_rst_wr_ptr", 32'(ctl.wr_ptr), 1);

    // A few random samples with varying hold and stall
    for (int i = 0; i < 6; i++) begin
      send(8'($urandom_range(0, 255)), int'($urandom_range(1, 3)));
      recv("rand", int'($urandom_range(0, 3)), 1'b0);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
